itrx_apbm_spi_arb: RTL and testbench
====================================

Name: itrx_apbm_spi_arb

Overview:
Two-requester APB master arbiter and sequencer in the pclk domain of the SPI-to-APB master bridge. Port 0 is the SPI frame decoder and port 1 is the local boot/config sequencer. The block grants one requester at a time with round-robin fairness, drives the APB SETUP/ACCESS protocol, and returns read data and error status to the granted requester.

Parameters:
ADDR_W, 16, APB address width.
DATA_W, 32, APB data width (8, 16 or 32).
TMO_CYC, 64, ACCESS-phase cycles before forced termination (timeout build only); legal range 2..255.

Ports:
pclk  in  1  APB clock; all logic on rising edge.
rst  in  1  Reset; synchronous, active-high.
req0  in  1  Port 0 request; level, held until done0.
req0_write  in  1  Port 0 direction, 1=write; held with req0.
req0_addr  in  ADDR_W  Port 0 address; held with req0.
req0_wdata  in  DATA_W  Port 0 write data; held with req0.
done0  out  1  Port 0 completion pulse, 1 cycle.
req1, req1_write, req1_addr, req1_wdata, done1  as port 0, for port 1.
rsp_rdata  out  DATA_W  Read data; valid in the done cycle, 0 for writes.
rsp_err  out  1  pslverr or timeout; valid in the done cycle.
paddr  out  ADDR_W  APB address.
pwrite  out  1  APB direction.
pwdata  out  DATA_W  APB write data.
psel  out  1  APB select.
penable  out  1  APB enable.
prdata  in  DATA_W  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.
busy  out  1  High in SETUP or ACCESS.
tmo_evt  out  1  Timeout pulse, 1 cycle; tied 0 without the macro.

Behaviour:
- Reset: state=IDLE, last_gnt=1 (so port 0 wins first). All outputs and registered address/data are 0.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port that is not last_gnt.
  - On grant, register addr/write/wdata into paddr/pwrite/pwdata (pwdata=0 for reads), update last_gnt, and go to SETUP.
- SETUP: psel=1, penable=0, lasting exactly 1 cycle. Then go to ACCESS.
- ACCESS
  - psel=1, penable=1.
  - On pready=1: register prdata into rsp_rdata (reads only; 0 for writes), register pslverr into rsp_err, pulse done of the granted port next cycle, return to IDLE, and drop psel/penable.
- Response outputs: done pulses one cycle after the pready cycle. rsp_rdata and rsp_err hold until the next done pulse.
- Turnaround: at least one IDLE cycle with psel=0 between transfers. Minimum transfer time from grant to done is 3 cycles (SETUP, ACCESS with pready, done).
- Request withdrawal: a requester dropping req before done is a protocol violation. The transfer still completes and done still pulses.
- Port 0 requirement: req0 must deassert in the cycle after done0, or a new transfer starts. Port 1 same.
- Reset mid-transfer: FSM returns to IDLE and psel/penable go to 0 on the next edge. No done is issued for the aborted transfer.
- paddr/pwrite/pwdata are stable from SETUP until the done cycle.
- done0 and done1 are never high together.

Optional Feature:
Macro ITRX_APBM_ARB_TMO_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TMO_CYC-1 with pready still 0: end the transfer as if pready=1 with rsp_err=1 and rsp_rdata=0, and pulse tmo_evt with done.
  - pready arriving in the same cycle as expiry wins, so it is a normal completion with no tmo_evt.
- Not defined: ACCESS waits indefinitely for pready, no counter is instantiated, and tmo_evt=0.

Test Plan:
- Port 0 write, addr 0x0010, wdata 0xA5A5_0001, pready high in the first ACCESS cycle -> psel on cycles 1-2, penable on cycle 2, done0 on cycle 3, rsp_err=0, rsp_rdata=0.
- Port 1 read, addr 0x0020, prdata 0x1234_5678, pready asserted after 3 wait cycles -> done1 one cycle after pready, rsp_rdata=0x1234_5678, paddr held throughout.
- req0 and req1 asserted together and re-asserted continuously after reset -> grant order 0,1,0,1, one psel=0 cycle between transfers, done0 and done1 never simultaneous.
- Port 0 read with pslverr=1 on the pready cycle -> done0 with rsp_err=1 and rsp_rdata=prdata.
- ITRX_APBM_ARB_TMO_EN, TMO_CYC=4, pready held 0 -> after 4 ACCESS cycles: done, rsp_err=1, rsp_rdata=0, tmo_evt=1, then IDLE. Repeat with pready=1 on the expiry cycle -> tmo_evt=0, rsp_err=pslverr.
- rst=1 asserted during the ACCESS of a port 1 write -> psel=penable=0 next edge, no done1, and the next request is granted to port 0.

Source files
------------

// File: rtl/itrx_apbm_spi_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : itrx_apbm_spi_arb_if
// Description : Requester, response and APB bundle of the SPI-to-APB master
//               arbiter; master modport is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface itrx_apbm_spi_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              done0;
    logic              req1;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              done1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              busy;
    logic              tmo_evt;

    modport master (
        input  req0, req0_write, req0_addr, req0_wdata,
        input  req1, req1_write, req1_addr, req1_wdata,
        input  prdata, pready, pslverr,
        output done0, done1, rsp_rdata, rsp_err,
        output paddr, pwrite, pwdata, psel, penable, busy, tmo_evt
    );

    modport slave (
        output req0, req0_write, req0_addr, req0_wdata,
        output req1, req1_write, req1_addr, req1_wdata,
        output prdata, pready, pslverr,
        input  done0, done1, rsp_rdata, rsp_err,
        input  paddr, pwrite, pwdata, psel, penable, busy, tmo_evt
    );
endinterface
`default_nettype wire

// File: rtl/itrx_apbm_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : itrx_apbm_spi_arb
// Description : Round-robin two-port APB master arbiter/sequencer (pclk domain).
//               Optional ACCESS timeout enabled by macro ITRX_APBM_ARB_TMO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module itrx_apbm_spi_arb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 64
) (
    input  logic                 pclk,
    input  logic                 rst,
    itrx_apbm_spi_arb_if.master  bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_gnt;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_done0;
    logic              r_done1;
    logic              w_psel;
    logic              w_penable;
    logic              w_grant;
    logic              w_grant_port;
    logic              w_complete;
    logic              w_tmo_exp;
    logic              w_req0;
    logic              w_req1;

    // A port is ignored while its done is high so a requester that drops req
    // in the cycle after done does not get a spurious second transfer.
    assign w_req0 = bus.req0 & ~r_done0;
    assign w_req1 = bus.req1 & ~r_done1;

`ifdef ITRX_APBM_ARB_TMO_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TMO_CYC - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_tmo_evt;

    assign w_tmo_exp = (r_state == c_ST_ACCESS) && !bus.pready && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
            r_tmo_evt <= 1'b0;
        end else begin
            r_tmo_evt <= w_complete & w_tmo_exp;
            if (r_state == c_ST_SETUP) begin
                r_tmo_cnt <= 8'd0;
            end else if ((r_state == c_ST_ACCESS) && !bus.pready) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign bus.tmo_evt = r_tmo_evt;
`else
    assign w_tmo_exp   = 1'b0;
    assign bus.tmo_evt = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_psel       = 1'b0;
        w_penable    = 1'b0;
        w_grant      = 1'b0;
        w_grant_port = r_last_gnt;
        w_complete   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_grant      = 1'b1;
                    w_grant_port = (w_req0 & w_req1) ? ~r_last_gnt : w_req1;
                    w_next_state = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_psel       = 1'b1;
                w_next_state = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.pready || w_tmo_exp) begin
                    w_complete   = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_last_gnt  <= 1'b1;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
        end else begin
            // r_last_gnt holds the port currently being served until the next grant.
            r_done0 <= w_complete & ~r_last_gnt;
            r_done1 <= w_complete &  r_last_gnt;
            if (w_grant) begin
                r_last_gnt <= w_grant_port;
                if (w_grant_port) begin
                    r_paddr  <= bus.req1_addr;
                    r_pwrite <= bus.req1_write;
                    r_pwdata <= bus.req1_write ? bus.req1_wdata : '0;
                end else begin
                    r_paddr  <= bus.req0_addr;
                    r_pwrite <= bus.req0_write;
                    r_pwdata <= bus.req0_write ? bus.req0_wdata : '0;
                end
            end
            if (w_complete) begin
                r_rsp_rdata <= (r_pwrite || w_tmo_exp) ? '0 : bus.prdata;
                r_rsp_err   <= w_tmo_exp ? 1'b1 : bus.pslverr;
            end
        end
    end

    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.paddr     = r_paddr;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
    assign bus.psel      = w_psel;
    assign bus.penable   = w_penable;
    assign bus.busy      = w_psel;

endmodule
`default_nettype wire

// File: tb/tb_itrx_apbm_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_itrx_apbm_spi_arb
// Description : Directed self-checking bench for itrx_apbm_spi_arb; inputs are
//               driven and outputs sampled on the falling edge of pclk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itrx_apbm_spi_arb;

    logic pclk;
    logic rst;
    int   n_checks;
    int   n_fail;

    itrx_apbm_spi_arb_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    itrx_apbm_spi_arb #(.ADDR_W(16), .DATA_W(32), .TMO_CYC(4)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1 = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge pclk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.busy, bus.done0, bus.done1, bus.rsp_err, bus.tmo_evt} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 0000000",
                     {bus.psel, bus.penable, bus.busy, bus.done0, bus.done1, bus.rsp_err, bus.tmo_evt});
        end
        n_checks++;
        if ({bus.paddr, bus.pwrite, bus.pwdata, bus.rsp_rdata} !== 81'd0) begin
            n_fail++;
            $display("FAIL reset_data: paddr %h pwrite %b pwdata %h rdata %h exp all 0",
                     bus.paddr, bus.pwrite, bus.pwdata, bus.rsp_rdata);
        end
        rst = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (bus.psel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: psel %b exp 0", bus.psel);
        end
    endtask

    task automatic test_write0();
        bus.req0 = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 16'h0010; bus.req0_wdata = 32'hA5A5_0001;
        bus.pready = 1'b1; bus.prdata = 32'hFFFF_FFFF;
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.done0, bus.busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL wr0_setup: psel/penable/done0/busy %b exp 1001", {bus.psel, bus.penable, bus.done0, bus.busy});
        end
        n_checks++;
        if ({bus.paddr, bus.pwrite, bus.pwdata} !== {16'h0010, 1'b1, 32'hA5A5_0001}) begin
            n_fail++;
            $display("FAIL wr0_bus: paddr %h pwrite %b pwdata %h exp 0010 1 a5a50001", bus.paddr, bus.pwrite, bus.pwdata);
        end
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.done0} !== 3'b110) begin
            n_fail++;
            $display("FAIL wr0_access: psel/penable/done0 %b exp 110", {bus.psel, bus.penable, bus.done0});
        end
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.done0, bus.done1} !== 4'b0010) begin
            n_fail++;
            $display("FAIL wr0_done: psel/penable/done0/done1 %b exp 0010", {bus.psel, bus.penable, bus.done0, bus.done1});
        end
        n_checks++;
        if ({bus.rsp_err, bus.rsp_rdata} !== 33'd0) begin
            n_fail++;
            $display("FAIL wr0_rsp: err %b rdata %h exp 0 00000000", bus.rsp_err, bus.rsp_rdata);
        end
        n_checks++;
        if ({bus.paddr, bus.pwdata} !== {16'h0010, 32'hA5A5_0001}) begin
            n_fail++;
            $display("FAIL wr0_hold: paddr %h pwdata %h exp 0010 a5a50001", bus.paddr, bus.pwdata);
        end
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.done0} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr0_no_regrant: psel/done0 %b exp 00", {bus.psel, bus.done0});
        end
        bus.req0 = 1'b0; bus.pready = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_read1_wait();
        bus.req1 = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 16'h0020; bus.req1_wdata = 32'h5555_5555;
        bus.prdata = 32'h1234_5678; bus.pready = 1'b0;
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata} !== {2'b10, 16'h0020, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rd1_setup: psel %b penable %b paddr %h pwrite %b pwdata %h exp 1 0 0020 0 00000000",
                     bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            n_checks++;
            if ({bus.psel, bus.penable, bus.done1, bus.paddr} !== {3'b110, 16'h0020}) begin
                n_fail++;
                $display("FAIL rd1_wait%0d: psel/penable/done1 %b paddr %h exp 110 0020",
                         i, {bus.psel, bus.penable, bus.done1}, bus.paddr);
            end
        end
        @(negedge pclk);
        n_checks++;
        if ({bus.penable, bus.done1, bus.paddr} !== {2'b10, 16'h0020}) begin
            n_fail++;
            $display("FAIL rd1_ready_cyc: penable/done1 %b paddr %h exp 10 0020", {bus.penable, bus.done1}, bus.paddr);
        end
        bus.pready = 1'b1;
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.done1, bus.done0} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rd1_done: psel/penable/done1/done0 %b exp 0010", {bus.psel, bus.penable, bus.done1, bus.done0});
        end
        n_checks++;
        if ({bus.rsp_err, bus.rsp_rdata} !== {1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL rd1_rsp: err %b rdata %h exp 0 12345678", bus.rsp_err, bus.rsp_rdata);
        end
        bus.pready = 1'b0;
        @(negedge pclk);
        bus.req1 = 1'b0;
        n_checks++;
        if ({bus.psel, bus.done1, bus.rsp_rdata} !== {2'b00, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL rd1_after: psel/done1 %b rdata %h exp 00 12345678", {bus.psel, bus.done1}, bus.rsp_rdata);
        end
        @(negedge pclk);
    endtask

    task automatic test_back_to_back();
        int grants;
        int last_setup;
        logic exp_port;
        do_reset();
        bus.req0 = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 16'h0100; bus.req0_wdata = 32'h0000_0100;
        bus.req1 = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = 16'h0200; bus.req1_wdata = 32'h0000_0200;
        bus.pready = 1'b1;
        grants = 0; last_setup = -1; exp_port = 1'b0;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            @(negedge pclk);
            n_checks++;
            if (bus.done0 && bus.done1) begin
                n_fail++;
                $display("FAIL b2b_dual_done: cycle %0d both done high", cyc);
            end
            if (bus.done0 || bus.done1) begin
                n_checks++;
                if (bus.psel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_turnaround: cycle %0d psel %b exp 0", cyc, bus.psel);
                end
            end
            if (bus.psel && !bus.penable) begin
                n_checks++;
                if (bus.paddr !== (exp_port ? 16'h0200 : 16'h0100)) begin
                    n_fail++;
                    $display("FAIL b2b_order: grant %0d paddr %h exp %h", grants, bus.paddr,
                             exp_port ? 16'h0200 : 16'h0100);
                end
                if (last_setup >= 0) begin
                    n_checks++;
                    if (cyc - last_setup != 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: grant %0d gap %0d exp 3", grants, cyc - last_setup);
                    end
                end
                last_setup = cyc;
                exp_port   = ~exp_port;
                grants++;
            end
        end
        n_checks++;
        if (grants != 4) begin
            n_fail++;
            $display("FAIL b2b_grants: got %0d exp 4 within cycle budget", grants);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) @(negedge pclk);
        n_checks++;
        if (bus.psel !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_settle: psel %b exp 0", bus.psel);
        end
        bus.pready = 1'b0;
    endtask

    task automatic test_slverr0();
        bus.req0 = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 16'h0030;
        bus.prdata = 32'hDEAD_BEEF; bus.pslverr = 1'b1; bus.pready = 1'b1;
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 16'h0030}) begin
            n_fail++;
            $display("FAIL err0_setup: psel/penable %b paddr %h exp 10 0030", {bus.psel, bus.penable}, bus.paddr);
        end
        @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({bus.done0, bus.done1, bus.rsp_err, bus.rsp_rdata} !== {3'b101, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL err0_done: done0/done1/err %b rdata %h exp 101 deadbeef",
                     {bus.done0, bus.done1, bus.rsp_err}, bus.rsp_rdata);
        end
        @(negedge pclk);
        bus.req0 = 1'b0; bus.pslverr = 1'b0; bus.pready = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid();
        bus.req1 = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = 16'h0040; bus.req1_wdata = 32'h0000_4040;
        bus.pready = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b11, 16'h0040}) begin
            n_fail++;
            $display("FAIL rstmid_access: psel/penable %b paddr %h exp 11 0040", {bus.psel, bus.penable}, bus.paddr);
        end
        rst = 1'b1;
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.done1} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_abort: psel/penable/done1 %b exp 000", {bus.psel, bus.penable, bus.done1});
        end
        rst = 1'b0;
        bus.req0 = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 16'h0050;
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.done1} !== {2'b10, 16'h0050, 2'b00}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: psel/penable %b paddr %h pwrite %b done1 %b exp 10 0050 0 0",
                     {bus.psel, bus.penable}, bus.paddr, bus.pwrite, bus.done1);
        end
        bus.req1 = 1'b0; bus.pready = 1'b1; bus.prdata = 32'h0000_5050;
        @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({bus.done0, bus.done1, bus.rsp_rdata} !== {2'b10, 32'h0000_5050}) begin
            n_fail++;
            $display("FAIL rstmid_done0: done0/done1 %b rdata %h exp 10 00005050", {bus.done0, bus.done1}, bus.rsp_rdata);
        end
        @(negedge pclk);
        bus.req0 = 1'b0; bus.pready = 1'b0;
        @(negedge pclk);
    endtask

`ifdef ITRX_APBM_ARB_TMO_EN
    task automatic test_timeout();
        bus.req0 = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 16'h0060;
        bus.prdata = 32'hFFFF_FFFF; bus.pready = 1'b0; bus.pslverr = 1'b0;
        @(negedge pclk);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            n_checks++;
            if ({bus.psel, bus.penable, bus.done0, bus.tmo_evt} !== 4'b1100) begin
                n_fail++;
                $display("FAIL tmo_wait%0d: psel/penable/done0/tmo %b exp 1100", i,
                         {bus.psel, bus.penable, bus.done0, bus.tmo_evt});
            end
        end
        @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.done0, bus.tmo_evt, bus.rsp_err, bus.rsp_rdata} !== {5'b00111, 32'h0}) begin
            n_fail++;
            $display("FAIL tmo_expire: psel/penable/done0/tmo/err %b rdata %h exp 00111 00000000",
                     {bus.psel, bus.penable, bus.done0, bus.tmo_evt, bus.rsp_err}, bus.rsp_rdata);
        end
        @(negedge pclk);
        bus.req0 = 1'b0;
        n_checks++;
        if ({bus.psel, bus.tmo_evt} !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_after: psel/tmo %b exp 00", {bus.psel, bus.tmo_evt});
        end
        @(negedge pclk);
        bus.req0 = 1'b1;
        @(negedge pclk);
        for (int i = 0; i < 3; i++) @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({bus.penable, bus.done0} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_race_wait: penable/done0 %b exp 10", {bus.penable, bus.done0});
        end
        bus.pready = 1'b1; bus.prdata = 32'h0BAD_F00D;
        @(negedge pclk);
        n_checks++;
        if ({bus.done0, bus.tmo_evt, bus.rsp_err, bus.rsp_rdata} !== {3'b100, 32'h0BAD_F00D}) begin
            n_fail++;
            $display("FAIL tmo_race: done0/tmo/err %b rdata %h exp 100 0badf00d",
                     {bus.done0, bus.tmo_evt, bus.rsp_err}, bus.rsp_rdata);
        end
        @(negedge pclk);
        bus.req0 = 1'b0; bus.pready = 1'b0;
        @(negedge pclk);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_write0();
        test_read1_wait();
        test_back_to_back();
        test_slverr0();
        test_reset_mid();
`ifdef ITRX_APBM_ARB_TMO_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
